mvtr_mon: RTL and testbench
===========================

// Module: mvtr_mon
// PURPOSE
//  Registered M-way majority voter with per-replica fault monitoring; successor of the combinational voter.
//  Votes M replicas of an N-bit vector each valid beat, registers the result, and tracks which replica disagrees.
//  Keeps saturating per-replica error counters and sticky persistent-fault flags.
//  Sits after TMR-triplicated registers/FSMs in the RU datapath; counters/flags feed slow-control status registers.
// PARAMETERS
//  M        3   number of replicas (>=2)
//  N        8   width of one replica vector
//  CNT_W    8   width of each per-replica error counter
//  PERSIST  4   consecutive disagreeing beats that set a replica's fault flag (>=1)
// PORTS
//  clk_i      in   1        single clock; all logic on rising edge
//  rst_i      in   1        synchronous, active-high reset
//  vtr_i      in   M*N      replica h occupies bits [h*N +: N]
//  valid_i    in   1        vtr_i valid this cycle
//  clr_i      in   1        clear error counters, streak counters and fault flags
//  vtr_o      out  N        voted vector (registered)
//  valid_o    out  1        vtr_o updated this cycle
//  warn_o     out  1        at least one replica disagreed on the beat now on vtr_o
//  dis_o      out  M        per-replica disagreement on the beat now on vtr_o
//  fault_o    out  M        sticky: replica h disagreed on PERSIST consecutive valid beats
//  err_cnt_o  out  M*CNT_W  per-replica saturating disagreement count, replica h at [h*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset: vtr_o=0, valid_o=0, warn_o=0, dis_o=0, fault_o=0, all error and streak counters 0.
//  - Latency 1: beat with valid_i=1 at edge k appears on vtr_o/valid_o/warn_o/dis_o after edge k.
//  - valid_i=0: valid_o=0, vtr_o holds, warn_o=0, dis_o=0; counters and streaks unchanged.
//  - Vote per bit: 1 iff ones among voters > (voter count >> 1); ties for even count resolve to 0.
//  - Disagreement: replica h disagrees iff its N-bit vector != voted vector (any bit differs).
//  - warn_o = |dis_o.
//  - err_cnt[h] += 1 per valid beat with dis[h]=1; saturates at 2^CNT_W-1, no wrap.
//  - streak[h]: +1 on valid beat with dis[h]=1, 0 on valid beat with dis[h]=0; saturates at PERSIST.
//  - fault_o[h] set on the edge where streak[h] reaches PERSIST; stays set until clr_i or rst_i.
//  - clr_i=1: zeroes err_cnt, streak, fault_o on that edge; clear wins over a same-cycle disagreement
//    (that beat is not counted); vtr_o/valid_o/warn_o/dis_o still update normally for that beat.
//  - rst_i mid-stream: in-flight beat discarded, all state returns to reset values next edge.
//  - Width rules: counters CNT_W bits; streak counters $clog2(PERSIST+1) bits; vote count $clog2(M+1) bits.
// CONFIGURATION
//  MVTR_MON_EXCLUDE_EN defined: replicas with fault_o[h]=1 are excluded from the vote.
//    - Voter count = number of unflagged replicas; majority rule above applies to them only.
//    - Tie among remaining voters: output the lowest-index unflagged replica's bit.
//    - All replicas flagged: vtr_o follows replica 0.
//    - Excluded replicas still get dis/err_cnt evaluated against the voted result.
//  MVTR_MON_EXCLUDE_EN undefined: all M replicas always vote; fault_o is status only.
// TESTING (M=3, N=8, CNT_W=4, PERSIST=4 unless stated)
//  1 Reset, then valid beat A5,A5,A5 -> next cycle vtr_o=A5, valid_o=1, warn_o=0, dis_o=000, counters 0.
//  2 Beat A5,A5,5A (replica 2 bad) -> vtr_o=A5, warn_o=1, dis_o=100, err_cnt[2]=1.
//  3 Replica 2 bad 4 consecutive valid beats (idle gaps in between) -> fault_o=100 after 4th beat;
//    bad beat 3 then good beat then bad beat -> streak restarts, no fault.
//  4 Replica 0 bad 20 beats -> err_cnt[0] stops at 15; clr_i together with a bad beat -> err_cnt[0]=0, fault_o=0.
//  5 M=4: bits 1,1,0,0 -> voted 0 (macro off); with MVTR_MON_EXCLUDE_EN and replica 3 flagged, replicas
//    0,1,2 = FF,00,00 -> vtr_o=00; replicas 1,3 flagged, 0,2 = FF,00 -> tie -> vtr_o=FF (replica 0).
//  6 rst_i asserted the cycle after a valid beat with faults set -> all outputs 0 next edge.

Source files
------------

// File: rtl/mvtr_mon_if.sv
// mvtr_mon_if: replica/vote/status bundle between a voter and its producer/consumer
interface mvtr_mon_if #(
   parameter int M     = 3,
   parameter int N     = 8,
   parameter int CNT_W = 8
);
   logic [M*N-1:0]     vtr_i;
   logic               valid_i;
   logic               clr_i;
   logic [N-1:0]       vtr_o;
   logic               valid_o;
   logic               warn_o;
   logic [M-1:0]       dis_o;
   logic [M-1:0]       fault_o;
   logic [M*CNT_W-1:0] err_cnt_o;
   modport master (output vtr_i, valid_i, clr_i,
                   input  vtr_o, valid_o, warn_o, dis_o, fault_o, err_cnt_o);
   modport slave  (input  vtr_i, valid_i, clr_i,
                   output vtr_o, valid_o, warn_o, dis_o, fault_o, err_cnt_o);
endinterface

// File: rtl/mvtr_mon.sv
// mvtr_mon: registered M-way majority voter with per-replica error counters and sticky fault flags.
// Optional macro MVTR_MON_EXCLUDE_EN: flagged replicas drop out of the vote (ties go to the lowest-index
// unflagged replica, all flagged follows replica 0).
module mvtr_mon #(
   parameter int M       = 3,
   parameter int N       = 8,
   parameter int CNT_W   = 8,
   parameter int PERSIST = 4
) (
   input logic        clk_i,
   input logic        rst_i,
   mvtr_mon_if.slave  bus
);
   localparam int CW = $clog2(M + 1);
   localparam int SW = $clog2(PERSIST + 1);
   logic [M-1:0]       act;
   logic [N-1:0]       vote;
   logic [M-1:0]       dis;
   logic [CW-1:0]      ones;
   logic [CNT_W-1:0]   err    [M];
   logic [SW-1:0]      streak [M];
`ifdef MVTR_MON_EXCLUDE_EN
   logic [CW-1:0]      nvot;
   logic               first;
`endif
   // bitwise vote over the active replicas, then per-replica disagreement against the result
   always_comb begin
`ifdef MVTR_MON_EXCLUDE_EN
      act  = ~bus.fault_o;
      nvot = '0;
      for (int h = 0; h < M; h++) nvot = nvot + CW'(act[h]);
`else
      act = '1;
`endif
      vote = '0;
      ones = '0;
      for (int b = 0; b < N; b++) begin
         ones = '0;
         for (int h = 0; h < M; h++) ones = ones + CW'(act[h] & bus.vtr_i[h*N+b]);
`ifdef MVTR_MON_EXCLUDE_EN
         first = bus.vtr_i[b];
         for (int h = M - 1; h >= 0; h--) if (act[h]) first = bus.vtr_i[h*N+b];
         vote[b] = ({ones, 1'b0} == {1'b0, nvot}) ? first : (ones > (nvot >> 1));
`else
         vote[b] = ones > CW'(M / 2);
`endif
      end
      dis = '0;
      for (int h = 0; h < M; h++) dis[h] = bus.vtr_i[h*N +: N] != vote;
   end
   // output register plus saturating error/streak counters and sticky fault flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.vtr_o   <= '0;
         bus.valid_o <= 1'b0;
         bus.warn_o  <= 1'b0;
         bus.dis_o   <= '0;
         bus.fault_o <= '0;
         for (int h = 0; h < M; h++) begin
            err[h]    <= '0;
            streak[h] <= '0;
         end
      end else begin
         bus.valid_o <= bus.valid_i;
         bus.warn_o  <= bus.valid_i & (|dis);
         bus.dis_o   <= bus.valid_i ? dis : '0;
         if (bus.valid_i) bus.vtr_o <= vote;
         for (int h = 0; h < M; h++) begin
            if (bus.clr_i) begin
               err[h]         <= '0;
               streak[h]      <= '0;
               bus.fault_o[h] <= 1'b0;
            end else if (bus.valid_i) begin
               if (dis[h] && err[h] != '1) err[h] <= err[h] + 1'b1;
               streak[h] <= !dis[h] ? '0 : (streak[h] == SW'(PERSIST)) ? streak[h] : streak[h] + 1'b1;
               if (dis[h] && streak[h] >= SW'(PERSIST - 1)) bus.fault_o[h] <= 1'b1;
            end
         end
      end
   end
   for (genvar g = 0; g < M; g++) begin : g_cnt
      assign bus.err_cnt_o[g*CNT_W +: CNT_W] = err[g];
   end
endmodule

// File: tb/tb_mvtr_mon.sv
// tb_mvtr_mon: directed self-checking bench for mvtr_mon (M=3 main instance, M=4 tie/exclusion instance)
module tb_mvtr_mon;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   localparam logic [23:0] GOOD = {8'hA5, 8'hA5, 8'hA5};
   localparam logic [23:0] BAD2 = {8'h5A, 8'hA5, 8'hA5};
   localparam logic [23:0] BAD1 = {8'hA5, 8'h00, 8'hA5};
   localparam logic [23:0] BAD0 = {8'hA5, 8'hA5, 8'h00};
   mvtr_mon_if #(.M(3), .N(8), .CNT_W(4)) b3 ();
   mvtr_mon_if #(.M(4), .N(8), .CNT_W(4)) b4 ();
   mvtr_mon #(.M(3), .N(8), .CNT_W(4), .PERSIST(4)) dut3 (.clk_i(clk), .rst_i(rst), .bus(b3.slave));
   mvtr_mon #(.M(4), .N(8), .CNT_W(4), .PERSIST(1)) dut4 (.clk_i(clk), .rst_i(rst), .bus(b4.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic beat3(input logic [23:0] v, input logic vl, input logic cl);
      b3.vtr_i = v; b3.valid_i = vl; b3.clr_i = cl;
      @(posedge clk); #1;
   endtask
   task automatic beat4(input logic [31:0] v, input logic cl);
      b4.vtr_i = v; b4.valid_i = 1'b1; b4.clr_i = cl;
      @(posedge clk); #1;
      b4.valid_i = 1'b0; b4.clr_i = 1'b0;
   endtask
   initial begin
      b3.vtr_i = '0; b3.valid_i = 1'b0; b3.clr_i = 1'b0;
      b4.vtr_i = '0; b4.valid_i = 1'b0; b4.clr_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vtr", 32'(b3.vtr_o), 32'h0);
      chk("rst_valid", 32'(b3.valid_o), 32'h0);
      chk("rst_warn", 32'(b3.warn_o), 32'h0);
      chk("rst_dis", 32'(b3.dis_o), 32'h0);
      chk("rst_fault", 32'(b3.fault_o), 32'h0);
      chk("rst_err", 32'(b3.err_cnt_o), 32'h0);
      rst = 1'b0;
      beat3(GOOD, 1, 0);
      chk("t1_vtr", 32'(b3.vtr_o), 32'hA5);
      chk("t1_valid", 32'(b3.valid_o), 32'h1);
      chk("t1_warn", 32'(b3.warn_o), 32'h0);
      chk("t1_dis", 32'(b3.dis_o), 32'h0);
      chk("t1_err", 32'(b3.err_cnt_o), 32'h0);
      beat3(24'h0, 0, 0);
      chk("idle_valid", 32'(b3.valid_o), 32'h0);
      chk("idle_hold", 32'(b3.vtr_o), 32'hA5);
      chk("idle_dis", 32'(b3.dis_o), 32'h0);
      beat3(BAD2, 1, 0);
      chk("t2_vtr", 32'(b3.vtr_o), 32'hA5);
      chk("t2_warn", 32'(b3.warn_o), 32'h1);
      chk("t2_dis", 32'(b3.dis_o), 32'h4);
      chk("t2_err", 32'(b3.err_cnt_o), 32'h100);
      beat3(24'h0, 0, 0);
      beat3(BAD2, 1, 0);
      beat3(24'h0, 0, 0);
      beat3(BAD2, 1, 0);
      chk("t3_nofault3", 32'(b3.fault_o), 32'h0);
      beat3(24'h0, 0, 0);
      beat3(BAD2, 1, 0);
      chk("t3_fault4", 32'(b3.fault_o), 32'h4);
      chk("t3_err4", 32'(b3.err_cnt_o), 32'h400);
      beat3(GOOD, 1, 1);
      chk("t3_clr_fault", 32'(b3.fault_o), 32'h0);
      chk("t3_clr_err", 32'(b3.err_cnt_o), 32'h0);
      repeat (3) beat3(BAD2, 1, 0);
      beat3(GOOD, 1, 0);
      beat3(BAD2, 1, 0);
      chk("t3_restart_nofault", 32'(b3.fault_o), 32'h0);
      chk("t3_restart_err", 32'(b3.err_cnt_o), 32'h400);
      repeat (3) beat3(BAD2, 1, 0);
      chk("t3_refault", 32'(b3.fault_o), 32'h4);
      chk("t3_refault_err", 32'(b3.err_cnt_o), 32'h700);
      beat3(GOOD, 1, 1);
      repeat (15) beat3(BAD0, 1, 0);
      chk("t4_err15", 32'(b3.err_cnt_o), 32'h00F);
      chk("t4_fault0", 32'(b3.fault_o), 32'h1);
      repeat (5) beat3(BAD0, 1, 0);
      chk("t4_err_sat", 32'(b3.err_cnt_o), 32'h00F);
      beat3(BAD0, 1, 1);
      chk("t4_clr_err", 32'(b3.err_cnt_o), 32'h0);
      chk("t4_clr_fault", 32'(b3.fault_o), 32'h0);
      chk("t4_clr_dis", 32'(b3.dis_o), 32'h1);
      chk("t4_clr_warn", 32'(b3.warn_o), 32'h1);
      chk("t4_clr_vtr", 32'(b3.vtr_o), 32'hA5);
      beat3({8'hFF, 8'hF0, 8'h0F}, 1, 0);
      chk("mix_vtr", 32'(b3.vtr_o), 32'hFF);
      chk("mix_dis", 32'(b3.dis_o), 32'h3);
      repeat (4) beat3(BAD1, 1, 0);
      chk("t6_fault", 32'(b3.fault_o), 32'h2);
      rst = 1'b1;
      beat3(GOOD, 1, 0);
      chk("t6_vtr", 32'(b3.vtr_o), 32'h0);
      chk("t6_valid", 32'(b3.valid_o), 32'h0);
      chk("t6_warn", 32'(b3.warn_o), 32'h0);
      chk("t6_dis", 32'(b3.dis_o), 32'h0);
      chk("t6_fault_rst", 32'(b3.fault_o), 32'h0);
      chk("t6_err", 32'(b3.err_cnt_o), 32'h0);
      rst = 1'b0;
      b3.valid_i = 1'b0;
`ifdef MVTR_MON_EXCLUDE_EN
      beat4({8'h00, 8'h00, 8'hFF, 8'hFF}, 1);
      chk("m4_tie_all", 32'(b4.vtr_o), 32'hFF);
`else
      beat4({8'h00, 8'h00, 8'hFF, 8'hFF}, 1);
      chk("m4_tie_all", 32'(b4.vtr_o), 32'h00);
`endif
      beat4({8'hFF, 8'h00, 8'h00, 8'h00}, 0);
      chk("m4_flag3", 32'(b4.fault_o), 32'h8);
      beat4({8'h00, 8'h00, 8'h00, 8'hFF}, 1);
      chk("m4_excl3_vtr", 32'(b4.vtr_o), 32'h00);
      chk("m4_excl3_dis", 32'(b4.dis_o), 32'h1);
      beat4({8'hFF, 8'h00, 8'hFF, 8'h00}, 0);
      chk("m4_flag13", 32'(b4.fault_o), 32'hA);
      beat4({8'h00, 8'h00, 8'h00, 8'hFF}, 1);
`ifdef MVTR_MON_EXCLUDE_EN
      chk("m4_tie_rep0", 32'(b4.vtr_o), 32'hFF);
`else
      chk("m4_tie_rep0", 32'(b4.vtr_o), 32'h00);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
